// File: rtl/sbox_layer_ctrl_pkg.sv
// rtl/sbox_layer_ctrl_pkg.sv - shared types and constants for the masked S-box layer controller
package sbox_layer_ctrl_pkg;
   localparam int NIB_W        = 4;
   localparam int SBOX_LAT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;
endpackage

// File: rtl/sbox_tag_pipe.sv
// rtl/sbox_tag_pipe.sv - free-running valid/index delay line matched to the external sbox latency
module sbox_tag_pipe #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_vld,
   input  logic [IDX_W-1:0] i_idx,
   output logic             o_vld,
   output logic [IDX_W-1:0] o_idx
);
   logic [DEPTH-1:0] r_vld;
   logic [IDX_W-1:0] r_idx [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_idx[0] <= i_idx;
         for (int i = 1; i < DEPTH; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

   assign o_vld = r_vld[DEPTH-1];
   assign o_idx = r_idx[DEPTH-1];
endmodule

// File: rtl/sbox_layer_ctrl.sv
// rtl/sbox_layer_ctrl.sv - streams 2-share nibbles through an external masked sbox and reassembles the result
module sbox_layer_ctrl
   import sbox_layer_ctrl_pkg::*;
#(
   parameter int SBOX_LAT = SBOX_LAT_DEF,
   parameter int NIB      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*NIB-1:0]      state_0,
   input  logic [4*NIB-1:0]      state_1,
   output logic                  busy,
   output logic                  done,
   output logic [4*NIB-1:0]      out_0,
   output logic [4*NIB-1:0]      out_1,
   input  logic                  rnd_valid,
   output logic                  rnd_ready,
   input  logic [1:0]            rnd,
   output logic [NIB_W-1:0]      sb_x_0,
   output logic [NIB_W-1:0]      sb_x_1,
   output logic                  sb_r1,
   output logic                  sb_r2,
   input  logic [NIB_W-1:0]      sb_y_0,
   input  logic [NIB_W-1:0]      sb_y_1
);
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int CNT_W = $clog2(NIB + 1);

   state_t             r_state;
   logic [4*NIB-1:0]   r_s0, r_s1, r_out0, r_out1;
   logic [IDX_W-1:0]   r_issue_idx;
   logic [CNT_W-1:0]   r_ret_cnt;
   logic               r_done;
   logic               w_issue;
   logic               w_ret_vld;
   logic [IDX_W-1:0]   w_ret_idx;

   // Handshake is combinational so a nibble enters the sbox in the same cycle randomness is taken.
   assign w_issue   = (r_state == ST_ISSUE) && rnd_valid;
   assign rnd_ready = w_issue;
   assign sb_x_0    = w_issue ? r_s0[r_issue_idx*NIB_W +: NIB_W] : '0;
   assign sb_x_1    = w_issue ? r_s1[r_issue_idx*NIB_W +: NIB_W] : '0;
   assign sb_r1     = w_issue & rnd[0];
   assign sb_r2     = w_issue & rnd[1];

   sbox_tag_pipe #(
      .DEPTH (SBOX_LAT),
      .IDX_W (IDX_W)
   ) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (w_issue),
      .i_idx (r_issue_idx),
      .o_vld (w_ret_vld),
      .o_idx (w_ret_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_s0        <= '0;
         r_s1        <= '0;
         r_out0      <= '0;
         r_out1      <= '0;
         r_issue_idx <= '0;
         r_ret_cnt   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_ret_vld) begin
            r_out0[w_ret_idx*NIB_W +: NIB_W] <= sb_y_0;
            r_out1[w_ret_idx*NIB_W +: NIB_W] <= sb_y_1;
            r_ret_cnt <= r_ret_cnt + 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_s0        <= state_0;
                  r_s1        <= state_1;
                  r_issue_idx <= '0;
                  r_ret_cnt   <= '0;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (rnd_valid) begin
                  r_issue_idx <= r_issue_idx + 1'b1;
                  if (r_issue_idx == IDX_W'(NIB - 1)) r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Decide on the final return itself so done coincides with the last nibble landing.
               if (w_ret_vld && (r_ret_cnt == CNT_W'(NIB - 1))) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy  = (r_state != ST_IDLE);
   assign done  = r_done;
   assign out_0 = r_out0;
   assign out_1 = r_out1;
endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// tb/tb_sbox_layer_ctrl.sv - vector table plus scoreboard bench for sbox_layer_ctrl with a behavioural masked sbox
module tb_sbox_layer_ctrl;
   localparam int LAT = 4;
   localparam int NIB = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   state_0 = '0, state_1 = '0;
   logic          busy, done;
   logic [63:0]   out_0, out_1;
   logic          rnd_valid = 1'b0;
   logic          rnd_ready;
   logic [1:0]    rnd = '0;
   logic [3:0]    sb_x_0, sb_x_1, sb_y_0, sb_y_1;
   logic          sb_r1, sb_r2;

   always #5 clk = ~clk;

   sbox_layer_ctrl #(.SBOX_LAT(LAT), .NIB(NIB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .state_0(state_0), .state_1(state_1),
      .busy(busy), .done(done), .out_0(out_0), .out_1(out_1),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
      .sb_x_0(sb_x_0), .sb_x_1(sb_x_1), .sb_r1(sb_r1), .sb_r2(sb_r2),
      .sb_y_0(sb_y_0), .sb_y_1(sb_y_1)
   );

   function automatic logic [3:0] present_s(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
         4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
         4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
         4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] layer_ref(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < NIB; i++) r[4*i +: 4] = present_s(x[4*i +: 4]);
      return r;
   endfunction

   // Behavioural masked sbox: output mask built from r1/r2, LAT registered stages.
   logic [3:0] p_y0 [LAT];
   logic [3:0] p_y1 [LAT];
   initial for (int i = 0; i < LAT; i++) begin p_y0[i] = '0; p_y1[i] = '0; end
   always @(posedge clk) begin
      p_y0[0] <= present_s(sb_x_0 ^ sb_x_1) ^ {sb_r2, sb_r1, sb_r2, sb_r1};
      p_y1[0] <= {sb_r2, sb_r1, sb_r2, sb_r1};
      for (int i = 1; i < LAT; i++) begin
         p_y0[i] <= p_y0[i-1];
         p_y1[i] <= p_y1[i-1];
      end
   end
   assign sb_y_0 = p_y0[LAT-1];
   assign sb_y_1 = p_y1[LAT-1];

   typedef struct {
      logic [63:0] s0;
      logic [63:0] s1;
      logic [1:0]  r;
      logic        toggle;
      logic        mid_start;
      logic [63:0] exp_xor;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [63:0] x;
      logic [63:0] o1;
      int          lat;
   } exp_t;

   vec_t vecs [5];
   exp_t sb_q [$];
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int k, input vec_t v);
      exp_t e;
      int   hs = 0, bub_bad = 0, ndone = 0;
      e.x   = v.exp_xor;
      e.o1  = {16{v.r[1], v.r[0], v.r[1], v.r[0]}};
      e.lat = v.exp_lat;
      sb_q.push_back(e);
      @(negedge clk);
      state_0 = v.s0; state_1 = v.s1; rnd = v.r; rnd_valid = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         rnd_valid = v.toggle ? c[0] : 1'b1;
         start     = v.mid_start && (c == 5);
         #1;
         if (rnd_valid && rnd_ready) hs++;
         if (busy && !rnd_valid && (rnd_ready || sb_r1 || sb_r2 || sb_x_0 != 0 || sb_x_1 != 0))
            bub_bad++;
         if (done) begin
            ndone++;
            if (ndone == 1 && sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk($sformatf("v%0d_latency", k), 64'(c), 64'(e.lat));
               chk($sformatf("v%0d_share_xor", k), out_0 ^ out_1, e.x);
               chk($sformatf("v%0d_out_1", k), out_1, e.o1);
               if (v.mid_start) start = 1'b1;
            end
         end
      end
      start = 1'b0;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk($sformatf("v%0d_done_seen", k), 64'(ndone), 64'd1);
      end
      chk($sformatf("v%0d_done_count", k), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_handshakes", k), 64'(hs), 64'(NIB));
      chk($sformatf("v%0d_bubble_quiet", k), 64'(bub_bad), 64'd0);
      chk($sformatf("v%0d_idle_after", k), 64'(busy), 64'd0);
      chk($sformatf("v%0d_hold_xor", k), out_0 ^ out_1, v.exp_xor);
   endtask

   initial begin
      logic [63:0] ra, rb, rc;
      int          nd;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      vecs[0] = '{64'h0123456789ABCDEF, 64'h0, 2'b01, 1'b0, 1'b0, 64'hC56B90AD3EF84712, 21};
      vecs[1] = '{ra, ra, 2'b10, 1'b0, 1'b0, 64'hCCCCCCCCCCCCCCCC, 21};
      vecs[2] = '{64'h0123456789ABCDEF, 64'h0, 2'b11, 1'b1, 1'b0, 64'hC56B90AD3EF84712, 36};
      vecs[3] = '{rb, rc, 2'b00, 1'b0, 1'b1, layer_ref(rb ^ rc), 21};
      vecs[4] = '{rc, ra, 2'b01, 1'b1, 1'b1, layer_ref(rc ^ ra), 36};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {busy, done, rnd_ready, sb_r1, sb_r2, sb_x_0, sb_x_1},
          {12'h0, 52'h0});
      chk("reset_out_0", out_0, 64'h0);
      chk("reset_out_1", out_1, 64'h0);
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

      // Abort a pass mid-flight: everything clears at once and no done follows.
      @(negedge clk);
      state_0 = ra; state_1 = rb; rnd = 2'b11; rnd_valid = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl", {busy, done, rnd_ready, sb_r1, sb_r2, sb_x_0, sb_x_1}, 64'h0);
      chk("abort_out_0", out_0, 64'h0);
      chk("abort_out_1", out_1, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1 if (done || busy) nd++;
      end
      chk("abort_no_done", 64'(nd), 64'd0);

      run_vec(5, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
